sort_stream_ctrl: RTL and testbench

- Stream-side controller for the systolic sorting stack, which has ports hold, is_input, data_in and data_out and holds R_SZ entries.
- Accepts one frame of unsigned numbers over a valid/ready/last input stream and pushes them into the stack.
- Then pops the frame out largest-first over a valid/ready/last output stream.
- Sits between the upstream producer and the stack and owns every stack control signal: flush, load, turnaround, drain and backpressure.

---
 rtl/sort_stream_ctrl_pkg.sv | 7 +
 rtl/sort_stream_ctrl.sv | 64 ++++++
 tb/tb_sort_stream_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_stream_ctrl_pkg.sv
// sort_stream_ctrl_pkg: controller state encoding and default word/stack geometry shared by the controller and its bench
package sort_stream_ctrl_pkg;
  localparam int DEF_HBIT = 63;
  localparam int DEF_R_SZ = 256;
  localparam int WORD_W = DEF_HBIT + 1;
  typedef enum logic [1:0] {FLUSH, LOAD, TURN, DRAIN} state_t;
endpackage

// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl: loads a frame into the systolic sort stack and drains it largest-first; ports: clk/rst, s_* input stream, m_* sorted output stream, sticky overflow, stk_* stack controls/data
module sort_stream_ctrl
  import sort_stream_ctrl_pkg::*;
#(
  parameter int HBIT = DEF_HBIT,
  parameter int R_SZ = DEF_R_SZ,
  parameter int CNT_W = $clog2(R_SZ + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [HBIT:0] s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [HBIT:0] m_data,
  output logic          m_last,
  output logic          overflow,
  output logic          stk_hold,
  output logic          stk_is_input,
  output logic [HBIT:0] stk_data_in,
  input  logic [HBIT:0] stk_data_out
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(R_SZ);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] flush_cnt, cnt;
  logic s_hs, m_hs, fill_hs;
  assign s_hs = s_valid && s_ready;
  assign m_hs = m_valid && m_ready;
  assign fill_hs = s_hs && cnt == FULL - ONE;
  always_ff @(posedge clk)
    if (rst) state <= FLUSH;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (rst) begin
      flush_cnt <= FULL;
      cnt <= '0;
      overflow <= 1'b0;
    end else begin
      flush_cnt <= state == FLUSH ? flush_cnt - ONE : flush_cnt;
      cnt <= s_hs ? cnt + ONE : m_hs ? cnt - ONE : cnt;
      overflow <= overflow || (fill_hs && !s_last);
    end
  always_comb begin
    state_nxt = state;
    case (state)
      FLUSH:   state_nxt = flush_cnt == ONE ? LOAD : FLUSH;
      LOAD:    state_nxt = s_hs && (s_last || fill_hs) ? TURN : LOAD;
      TURN:    state_nxt = DRAIN;
      default: state_nxt = m_hs && m_last ? LOAD : DRAIN;
    endcase
  end
  always_comb begin
    s_ready = state == LOAD;
    stk_is_input = state == LOAD;
    m_valid = state == DRAIN;
    m_last = state == DRAIN && cnt == ONE;
    stk_hold = state == LOAD ? !s_valid : state == TURN ? 1'b1 : state == DRAIN ? !m_ready : 1'b0;
    stk_data_in = s_data;
    m_data = stk_data_out;
  end
endmodule

// File: tb/tb_sort_stream_ctrl.sv
// tb_sort_stream_ctrl: drives two controllers (full size and R_SZ=4) with behavioural stacks, checking output order against a sorted reference
module tb_sort_stream_ctrl;
  import sort_stream_ctrl_pkg::*;
  localparam int BR = DEF_R_SZ;
  localparam int TR = 4;
  localparam int W = DEF_HBIT + 1;
  typedef logic [W-1:0] word_t;
  typedef word_t arr_t [BR];
  logic clk = 0, rst = 1, sel = 0;
  logic s_valid = 0, s_last = 0, m_ready = 0;
  word_t s_data = '0;
  logic b_s_ready, b_m_valid, b_m_last, b_ovf, b_hold, b_isin;
  logic t_s_ready, t_m_valid, t_m_last, t_ovf, t_hold, t_isin;
  word_t b_m_data, b_din, b_dout, t_m_data, t_din, t_dout;
  logic o_s_ready, o_m_valid, o_m_last, o_ovf, o_hold, o_isin;
  word_t o_m_data, o_din;
  arr_t b_cells = '{default: 64'hDEAD_BEEF_0000_0001};
  arr_t t_cells = '{default: 64'hDEAD_BEEF_0000_0001};
  word_t got[$];
  int errors = 0, checks = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic arr_t stk_next(arr_t c, int cap, logic is_in, word_t v);
    arr_t n = '{default: '0};
    for (int i = 0; i < cap; i++)
      if (!is_in) n[i] = i + 1 < cap ? c[i + 1] : '0;
      else if (c[i] >= v) n[i] = c[i];
      else if (i == 0) n[i] = v;
      else n[i] = c[i - 1] >= v ? v : c[i - 1];
    return n;
  endfunction
  always @(posedge clk) b_cells <= b_hold ? b_cells : stk_next(b_cells, BR, b_isin, b_din);
  always @(posedge clk) t_cells <= t_hold ? t_cells : stk_next(t_cells, TR, t_isin, t_din);
  assign b_dout = b_cells[0];
  assign t_dout = t_cells[0];
  assign o_s_ready = sel ? t_s_ready : b_s_ready;
  assign o_m_valid = sel ? t_m_valid : b_m_valid;
  assign o_m_last = sel ? t_m_last : b_m_last;
  assign o_ovf = sel ? t_ovf : b_ovf;
  assign o_hold = sel ? t_hold : b_hold;
  assign o_isin = sel ? t_isin : b_isin;
  assign o_m_data = sel ? t_m_data : b_m_data;
  assign o_din = sel ? t_din : b_din;
  sort_stream_ctrl #(.HBIT(W - 1), .R_SZ(BR)) u_big (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data), .m_last(b_m_last), .overflow(b_ovf),
    .stk_hold(b_hold), .stk_is_input(b_isin), .stk_data_in(b_din), .stk_data_out(b_dout)
  );
  sort_stream_ctrl #(.HBIT(W - 1), .R_SZ(TR)) u_tiny (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(t_s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(t_m_valid), .m_ready(m_ready), .m_data(t_m_data), .m_last(t_m_last), .overflow(t_ovf),
    .stk_hold(t_hold), .stk_is_input(t_isin), .stk_data_in(t_din), .stk_data_out(t_dout)
  );
  task automatic do_reset(input int exp_flush);
    int n = 0;
    logic bad = 0, first_mv;
    @(negedge clk);
    rst = 1; s_valid = 0; s_last = 0; m_ready = 0;
    @(negedge clk);
    rst = 0;
    #1;
    first_mv = o_m_valid;
    while (!o_s_ready && n < 600) begin
      n++;
      if (o_m_valid !== 1'b0 || o_hold !== 1'b0 || o_isin !== 1'b0) bad = 1;
      @(negedge clk);
      #1;
    end
    checks++;
    if (first_mv !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b expected 0", first_mv); end
    checks++;
    if (n !== exp_flush) begin errors++; $display("FAIL flush_len: got %0d cycles expected %0d", n, exp_flush); end
    checks++;
    if (bad) begin errors++; $display("FAIL flush_outputs: got nonzero m_valid/stk_hold/stk_is_input expected 0"); end
    checks++;
    if (o_ovf !== 1'b0) begin errors++; $display("FAIL ovf_after_rst: got %b expected 0", o_ovf); end
  endtask
  task automatic send(input word_t w[$], input int gap_mode, input logic with_last, output int hs_c);
    hs_c = -1;
    foreach (w[k]) begin
      int g = gap_mode == 1 ? 2 : gap_mode == 2 ? int'($urandom_range(0, 2)) : 0;
      int t = 0;
      if (k > 0)
        repeat (g) begin
          @(negedge clk);
          s_valid = 0; s_last = 0; s_data = word_t'($urandom);
          #1;
          checks++;
          if (o_s_ready !== 1'b1 || o_hold !== 1'b1) begin
            errors++; $display("FAIL gap_hold: got ready=%b hold=%b expected 1 1", o_s_ready, o_hold);
          end
        end
      @(negedge clk);
      s_valid = 1; s_data = w[k]; s_last = with_last && k == w.size() - 1;
      #1;
      while (!o_s_ready && t < 600) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (t >= 600) begin
        errors++; checks++;
        $display("FAIL send_timeout: got no s_ready within %0d cycles expected ready", t);
        break;
      end
      checks++;
      if (o_hold !== 1'b0 || o_isin !== 1'b1 || o_din !== s_data) begin
        errors++;
        $display("FAIL load_ctrl: got hold=%b is_input=%b data_in=%0d expected 0 1 %0d", o_hold, o_isin, o_din, s_data);
      end
      if (k == w.size() - 1) hs_c = cyc;
    end
  endtask
  task automatic recv(input int n_exp, input int mode, input int hs_c, input int stop_after, input logic noise);
    int t = 0, k = 0, first = -1;
    logic stall = 0, bad_rdy = 0;
    word_t prev = '0;
    got.delete();
    while (k < stop_after && t < 2000) begin
      @(negedge clk);
      m_ready = mode == 0 ? 1'b1 : mode == 1 ? t % 3 == 0 : 1'($urandom_range(0, 1));
      s_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      s_last = 1'($urandom_range(0, 1));
      s_data = word_t'($urandom);
      #1;
      t++;
      if (o_s_ready) bad_rdy = 1;
      if (stall) begin
        checks++;
        if (o_m_valid !== 1'b1 || o_m_data !== prev) begin
          errors++; $display("FAIL stall_stable: got valid=%b data=%0d expected 1 %0d", o_m_valid, o_m_data, prev);
        end
      end
      if (o_m_valid && first < 0) first = cyc;
      stall = o_m_valid && !m_ready;
      prev = o_m_data;
      if (o_m_valid && m_ready) begin
        got.push_back(o_m_data);
        k++;
        checks++;
        if (o_m_last !== (k == n_exp)) begin
          errors++; $display("FAIL m_last: word %0d got %b expected %b", k, o_m_last, k == n_exp);
        end
        if (o_m_last) break;
      end
    end
    checks++;
    if (t >= 2000) begin errors++; $display("FAIL recv_timeout: got %0d words expected %0d", k, stop_after); end
    checks++;
    if (bad_rdy) begin errors++; $display("FAIL ready_in_drain: got s_ready=1 expected 0"); end
    if (hs_c >= 0) begin
      checks++;
      if (first != hs_c + 2) begin errors++; $display("FAIL latency: got cycle %0d expected %0d", first, hs_c + 2); end
    end
  endtask
  task automatic check_out(input string name, input word_t q[$], input int lim);
    word_t e[$];
    e = q;
    e.rsort();
    while (e.size() > lim) e.pop_back();
    checks++;
    if (got.size() !== e.size()) begin
      errors++; $display("FAIL %s_count: got %0d words expected %0d", name, got.size(), e.size());
    end else
      foreach (e[i]) begin
        checks++;
        if (got[i] !== e[i]) begin errors++; $display("FAIL %s_word%0d: got %0d expected %0d", name, i, got[i], e[i]); end
      end
  endtask
  task automatic check_ovf(input string name, input logic exp);
    checks++;
    if (o_ovf !== exp) begin errors++; $display("FAIL %s: got overflow=%b expected %b", name, o_ovf, exp); end
  endtask
  task automatic test_reset;
    sel = 0;
    do_reset(BR);
  endtask
  task automatic test_basic;
    word_t q[$];
    int hs;
    q = '{5, 1, 9, 3, 9};
    send(q, 0, 1, hs);
    recv(5, 0, hs, 5, 0);
    check_out("basic", q, 5);
    check_ovf("basic_ovf", 0);
  endtask
  task automatic test_backpressure;
    word_t q[$];
    int hs;
    q = '{5, 1, 9, 3, 9};
    send(q, 0, 1, hs);
    recv(5, 1, hs, 5, 0);
    check_out("bp", q, 5);
  endtask
  task automatic test_bubbles;
    word_t q[$];
    int hs;
    q = '{7, 0, 2};
    send(q, 1, 1, hs);
    recv(3, 0, hs, 3, 0);
    check_out("bubbles", q, 3);
    q = '{0};
    send(q, 0, 1, hs);
    recv(1, 0, hs, 1, 0);
    check_out("single_zero", q, 1);
  endtask
  task automatic test_full_frame;
    word_t q[$];
    int hs;
    for (int i = 0; i < BR; i++) q.push_back(word_t'($urandom_range(0, 1000)));
    send(q, 0, 1, hs);
    check_ovf("full_no_ovf", 0);
    recv(BR, 0, hs, BR, 0);
    check_out("full", q, BR);
  endtask
  task automatic test_random;
    for (int f = 0; f < 6; f++) begin
      word_t q[$];
      int hs;
      int len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        q.push_back($urandom_range(0, 3) == 0 ? {$urandom, $urandom} : word_t'($urandom_range(0, 15)));
      send(q, 2, 1, hs);
      recv(len, 2, hs, len, 1);
      check_out("random", q, len);
    end
    check_ovf("random_ovf", 0);
  endtask
  task automatic test_reset_mid_drain;
    word_t q[$];
    int hs;
    sel = 0;
    do_reset(BR);
    q = '{10, 20, 30, 40, 50};
    send(q, 0, 1, hs);
    recv(5, 0, hs, 2, 0);
    check_out("pre_rst", q, 2);
    do_reset(BR);
    q = '{3, 8};
    send(q, 0, 1, hs);
    recv(2, 0, hs, 2, 0);
    check_out("post_rst", q, 2);
  endtask
  task automatic test_overflow;
    word_t q[$];
    int hs;
    sel = 1;
    do_reset(TR);
    q = '{1, 2, 3, 4};
    send(q, 0, 0, hs);
    check_ovf("ovf_before_fill", 0);
    recv(4, 0, hs, 4, 0);
    check_ovf("ovf_set", 1);
    check_out("trunc", q, 4);
    q = '{5, 6};
    send(q, 0, 1, hs);
    recv(2, 0, hs, 2, 0);
    check_out("excess", q, 2);
    check_ovf("ovf_sticky", 1);
    do_reset(TR);
    sel = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit expected finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_bubbles;
    test_full_frame;
    test_random;
    test_reset_mid_drain;
    test_overflow;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
